// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
//
// Purpose : Shared definitions for the CPU / two-master DMA bus arbiter.
//           Holds the controller state encoding, the BusOwner codes, the
//           default tenure limits and two small helpers that turn a latched
//           DMA master index into its grant vector and its owner code.
//
// Contents:
//   arb_state_t       controller states CPU, DRAIN, GRANT, RELEASE
//   OWN_CPU/DMA0/DMA1 BusOwner encodings (3 is never driven)
//   MAX_HOLD_DEFAULT  default maximum consecutive grant cycles
//   CPU_MIN_DEFAULT   default minimum CPU-owned cycles between DMA tenures
//   LAST_RESET        last-served value after reset (DMA1, so DMA0 wins a tie)
//   grant_vec()       master index -> one-hot DmaGnt value
//   owner_code()      master index -> BusOwner value
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_CPU     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   localparam logic [1:0] OWN_CPU  = 2'd0;
   localparam logic [1:0] OWN_DMA0 = 2'd1;
   localparam logic [1:0] OWN_DMA1 = 2'd2;

   localparam int MAX_HOLD_DEFAULT = 16;
   localparam int CPU_MIN_DEFAULT  = 4;

   // Pretending DMA1 was served last makes DMA0 the first tie winner.
   localparam logic LAST_RESET = 1'b1;

   function automatic logic [1:0] grant_vec(input logic master);
      return master ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [1:0] owner_code(input logic master);
      return master ? OWN_DMA1 : OWN_DMA0;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
//
// Purpose : Two-way round-robin choice between the DMA masters. Purely
//           combinational; the caller latches the result when it commits
//           to a DMA tenure.
//
// Ports:
//   req     in  2  request level per master, bit n = master n
//   last    in  1  index of the master served most recently
//   winner  out 1  index of the chosen master (0 when nobody requests)
// -----------------------------------------------------------------------------
module arb_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

   // With both masters asking, the one not served last goes next; with a
   // single requester it simply wins regardless of history.
   always_comb begin
      if (req == 2'b11) begin
         winner = ~last;
      end else begin
         winner = req[1];
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Purpose : Arbitrates the shared bus between the CPU instruction fetch
//           path and two DMA masters. The CPU owns the bus by default; a
//           DMA tenure is framed by a one-cycle DRAIN (fetch stalled, no
//           grant yet) and a one-cycle RELEASE (grant gone, fetch still
//           stalled), so ownership never overlaps. A tenure is capped at
//           MAX_HOLD cycles and the CPU is guaranteed CPU_MIN cycles between
//           tenures unless stage 1 reports it is not fetching anyway.
//           Every output is a flop; no input reaches an output
//           combinationally.
//
// Parameters:
//   MAX_HOLD  1..255  maximum consecutive cycles one DMA master holds a grant
//   CPU_MIN   0..255  minimum CPU-owned cycles between DMA tenures
//
// Ports:
//   ClockIn        in  1  clock, rising edge
//   ResetIn        in  1  synchronous active-high reset
//   DmaReq         in  2  per-master request level, bit n = master n
//   DmaDone        in  2  per-master release pulse (only the granted one counts)
//   FetchSurpress  in  1  stage 1 fetch suppress; high = CPU idle on the bus
//   DmaGnt         out 2  one-hot-or-zero DMA grant
//   BusRequest     out 1  stalls instruction fetch while high
//   BusOwner       out 2  0 = CPU, 1 = DMA0, 2 = DMA1
// -----------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
   parameter int CPU_MIN  = CPU_MIN_DEFAULT
) (
   input  logic       ClockIn,
   input  logic       ResetIn,
   input  logic [1:0] DmaReq,
   input  logic [1:0] DmaDone,
   input  logic       FetchSurpress,
   output logic [1:0] DmaGnt,
   output logic       BusRequest,
   output logic [1:0] BusOwner
);

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
   localparam logic [7:0] CPU_MIN_C  = 8'(CPU_MIN);

   arb_state_t state;
   logic [7:0] cpu_cnt;
   logic [7:0] hold_cnt;
   logic       winner;
   logic       last;
   logic       pick;
   logic       cpu_window_open;
   logic       grant_end;

   arb_rr_pick u_pick (
      .req    (DmaReq),
      .last   (last),
      .winner (pick)
   );

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      // cpu_cnt holds the CPU cycles already completed; the +1 counts the
      // current one, so exactly CPU_MIN CPU cycles pass before DRAIN.
      cpu_window_open = (({1'b0, cpu_cnt} + 9'd1) >= {1'b0, CPU_MIN_C})
                        || FetchSurpress;
      // Done, dropped request and the hold limit all end the tenure the
      // same way; any combination of them is a single release.
      grant_end       = DmaDone[winner] || !DmaReq[winner]
                        || (hold_cnt == MAX_HOLD_C);
   end

   // NOTE: state and registered outputs use non-blocking assignments so
   // every flop samples the values from before this edge.
   always_ff @(posedge ClockIn) begin
      // NOTE: reset is sampled on the clock edge and wins over every other
      // condition, including an in-progress grant (no RELEASE cycle).
      if (ResetIn) begin
         state      <= ST_CPU;
         cpu_cnt    <= 8'd0;
         hold_cnt   <= 8'd0;
         winner     <= 1'b0;
         last       <= LAST_RESET;
         DmaGnt     <= 2'b00;
         BusRequest <= 1'b0;
         BusOwner   <= OWN_CPU;
      end else begin
         unique case (state)
            ST_CPU: begin
               if (cpu_cnt != 8'hFF) begin
                  cpu_cnt <= cpu_cnt + 8'd1;
               end
               if (|DmaReq && cpu_window_open) begin
                  state      <= ST_DRAIN;
                  winner     <= pick;
                  BusRequest <= 1'b1;
               end
            end

            // One cycle with fetch stalled and no grant lets the CPU
            // pipeline drain its outstanding access; inputs are ignored.
            ST_DRAIN: begin
               state    <= ST_GRANT;
               hold_cnt <= 8'd1;
               DmaGnt   <= grant_vec(winner);
               BusOwner <= owner_code(winner);
            end

            ST_GRANT: begin
               if (grant_end) begin
                  state    <= ST_RELEASE;
                  DmaGnt   <= 2'b00;
                  BusOwner <= OWN_CPU;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end

            // Grant is already gone; fetch stays stalled one more cycle so
            // the DMA master's last access completes before the CPU resumes.
            ST_RELEASE: begin
               state      <= ST_CPU;
               BusRequest <= 1'b0;
               cpu_cnt    <= 8'd0;
               hold_cnt   <= 8'd0;
               last       <= winner;
            end

            default: begin
               state <= ST_CPU;
            end
         endcase
      end
   end

endmodule
